// File: rtl/prog_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pl_ctrl_pkg
//  Description : Shared definitions for the program-load controller: FSM
//                state encoding, word size, bubble instruction and the
//                length-legality helper used when a load is started.
//  Revision    : 1.0 - initial release
// ============================================================================
package pl_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_RUN    = 3'd3,
      S_DRAIN  = 3'd4
   } state_e;

   localparam int          WORD_BYTES = 4;

   // addi x0,x0,0 - the bubble the core injects while core_hold is high
   localparam logic [31:0] NOP        = 32'h0000_0013;

   // A load length is legal when it is non-zero and fits in instruction memory
   function automatic logic len_ok(input logic [15:0] len, input int unsigned max_words);
      return (len != 16'd0) && (32'(len) <= max_words);
   endfunction

endpackage
`default_nettype wire

// File: rtl/prog_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_load_ctrl_if
//  Description : Program-word stream (valid/ready) and instruction-memory
//                load port bundled together.
//    s_valid / s_data / s_ready  : incoming program words
//    imem_we / imem_load_en      : memory write strobe and load clock enable
//    imem_addr / imem_data       : byte address and word being written
//  Modports    : slave  - the controller (sinks the stream, drives imem)
//                master - the environment (sources the stream, sees imem)
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_load_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              s_valid;
   logic [31:0]       s_data;
   logic              s_ready;
   logic              imem_we;
   logic              imem_load_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;

   modport slave (
      input  s_valid, s_data,
      output s_ready, imem_we, imem_load_en, imem_addr, imem_data
   );

   modport master (
      output s_valid, s_data,
      input  s_ready, imem_we, imem_load_en, imem_addr, imem_data
   );
endinterface
`default_nettype wire

// File: rtl/prog_load_ctrl_cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_counter
//  Description : Loadable down-counter that saturates at zero and flags the
//                terminal count.
//    clk, rst    : clock, synchronous active-low reset
//    i_load      : load i_load_val (has priority over i_en)
//    i_en        : decrement by one while non-zero
//    o_tc        : high while the count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module cycle_counter #(
   parameter int WIDTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_load,
   input  wire logic [WIDTH-1:0] i_load_val,
   input  wire logic             i_en,
   output logic                  o_tc
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/prog_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prog_load_ctrl
//  Description : Boot/run sequencer for the 5-stage RV core. Streams a
//                program into instruction memory while the core is held in
//                reset, settles the pipeline, runs, and drains on halt.
//    clk, rst         : clock, synchronous active-low reset
//    i_start          : pulse; begin loading i_cfg_len words (ignored if busy)
//    i_cfg_len        : number of words to load
//    bus              : program stream in, instruction-memory port out
//    i_halt_req       : level; stop the core
//    o_core_rst       : active-high core reset
//    o_core_hold      : freeze fetch / inject bubbles
//    o_busy           : not idle
//    o_done           : one-cycle pulse when the drain completes
//    o_err            : sticky error (bad length or inter-word timeout)
//    o_words_loaded   : words written since the last accepted start
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_load_ctrl
   import pl_ctrl_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int unsigned       MAX_WORDS  = 1024,
   parameter int                PIPE_DEPTH = 5,
   parameter int                TIMEOUT    = 65535
) (
   input  wire logic           clk,
   input  wire logic           rst,
   input  wire logic           i_start,
   input  wire logic [15:0]    i_cfg_len,
   prog_load_ctrl_if.slave     bus,
   input  wire logic           i_halt_req,
   output logic                o_core_rst,
   output logic                o_core_hold,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err,
   output logic [15:0]         o_words_loaded
);

   localparam int PD_W = $clog2(PIPE_DEPTH + 1);
   localparam int TO_W = $clog2(TIMEOUT + 1);

   state_e            r_state;
   state_e            w_next;

   logic [15:0]       r_len;
   logic [15:0]       r_words;
   logic [ADDR_W-1:0] r_next_addr;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [31:0]       r_imem_data;
   logic              r_imem_we;
   logic              r_done;
   logic              r_err;

   logic              w_s_ready;
   logic              w_accept;
   logic              w_last;
   logic              w_start_ok;
   logic              w_len_err;
   logic              w_timeout;
   logic              w_core_rst;
   logic              w_core_hold;

   logic              w_pd_load;
   logic              w_pd_en;
   logic              w_pd_tc;
   logic              w_to_load;
   logic              w_to_en;
   logic              w_to_tc;

   assign w_s_ready  = (r_state == S_LOAD);
   assign w_accept   = bus.s_valid & w_s_ready;
   assign w_last     = w_accept && ((r_words + 16'd1) == r_len);
   assign w_start_ok = i_start && len_ok(i_cfg_len, MAX_WORDS);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and core control
   // ------------------------------------------------------------------
   always_comb begin
      w_next      = r_state;
      w_core_rst  = 1'b1;
      w_core_hold = 1'b0;
      w_len_err   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (w_start_ok) begin
                  w_next = S_LOAD;
               end else begin
                  w_len_err = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (w_last) begin
               w_next = S_SETTLE;
            end else if (!w_accept && w_to_tc) begin
               w_timeout = 1'b1;
               w_next    = S_IDLE;
            end
         end
         S_SETTLE: begin
            w_core_hold = 1'b1;
            if (w_pd_tc) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            w_core_rst = 1'b0;
            if (i_halt_req) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_core_rst  = 1'b0;
            w_core_hold = 1'b1;
            if (w_pd_tc) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Settle/drain counter: loaded with PIPE_DEPTH-1 on entry so the
   // terminal count lands on the last of PIPE_DEPTH cycles.
   // ------------------------------------------------------------------
   assign w_pd_load = ((w_next == S_SETTLE) && (r_state != S_SETTLE)) ||
                      ((w_next == S_DRAIN)  && (r_state != S_DRAIN));
   assign w_pd_en   = (r_state == S_SETTLE) || (r_state == S_DRAIN);

   cycle_counter #(
      .WIDTH (PD_W)
   ) u_pd_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_pd_load),
      .i_load_val (PD_W'(PIPE_DEPTH - 1)),
      .i_en       (w_pd_en),
      .o_tc       (w_pd_tc)
   );

   // ------------------------------------------------------------------
   // Inter-word timeout: reloaded on LOAD entry and every accept; the
   // timeout fires on the TIMEOUT-th consecutive idle LOAD cycle.
   // ------------------------------------------------------------------
   assign w_to_load = ((w_next == S_LOAD) && (r_state != S_LOAD)) || w_accept;
   assign w_to_en   = (r_state == S_LOAD) && !w_accept;

   cycle_counter #(
      .WIDTH (TO_W)
   ) u_to_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_to_load),
      .i_load_val (TO_W'(TIMEOUT - 1)),
      .i_en       (w_to_en),
      .o_tc       (w_to_tc)
   );

   // ------------------------------------------------------------------
   // Load datapath, status flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_len       <= '0;
         r_words     <= '0;
         r_next_addr <= BASE_ADDR;
         r_imem_addr <= BASE_ADDR;
         r_imem_data <= '0;
         r_imem_we   <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_imem_we <= 1'b0;
         r_done    <= (r_state == S_DRAIN) && (w_next == S_IDLE);

         if ((r_state == S_IDLE) && w_start_ok) begin
            r_len       <= i_cfg_len;
            r_words     <= '0;
            r_next_addr <= BASE_ADDR;
            r_err       <= 1'b0;
         end

         if (w_len_err || w_timeout) begin
            r_err <= 1'b1;
         end

         if (w_accept) begin
            r_imem_we   <= 1'b1;
            r_imem_addr <= r_next_addr;
            r_imem_data <= bus.s_data;
            r_next_addr <= r_next_addr + ADDR_W'(WORD_BYTES);
            r_words     <= r_words + 16'd1;
         end
      end
   end

   assign bus.s_ready      = w_s_ready;
   assign bus.imem_we      = r_imem_we;
   assign bus.imem_load_en = r_imem_we;
   assign bus.imem_addr    = r_imem_addr;
   assign bus.imem_data    = r_imem_data;

   assign o_core_rst     = w_core_rst;
   assign o_core_hold    = w_core_hold;
   assign o_busy         = (r_state != S_IDLE);
   assign o_done         = r_done;
   assign o_err          = r_err;
   assign o_words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_prog_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_load_ctrl
//  Description : Self-checking bench for prog_load_ctrl. Accepted words are
//                queued with their expected address and compared against the
//                instruction-memory writes; length legality is table-driven.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prog_load_ctrl;

   localparam int          ADDR_W = 32;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam int          TO     = 8;
   localparam int          PD     = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] cfg_len = '0;
   logic        halt = 1'b0;
   logic        core_rst, core_hold, busy, done, err;
   logic [15:0] words;

   prog_load_ctrl_if #(.ADDR_W(ADDR_W)) bus_if ();

   prog_load_ctrl #(
      .ADDR_W     (ADDR_W),
      .BASE_ADDR  (BASE),
      .MAX_WORDS  (1024),
      .PIPE_DEPTH (PD),
      .TIMEOUT    (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_start        (start),
      .i_cfg_len      (cfg_len),
      .bus            (bus_if),
      .i_halt_req     (halt),
      .o_core_rst     (core_rst),
      .o_core_hold    (core_hold),
      .o_busy         (busy),
      .o_done         (done),
      .o_err          (err),
      .o_words_loaded (words)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_writes = 0;
   int          exp_idx  = 0;
   logic [63:0] sb_q[$];
   logic [63:0] sb_item;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard producer: every handshake queues {expected addr, data}
   always @(posedge clk) begin
      if (!rst) begin
         sb_q.delete();
         exp_idx = 0;
      end else begin
         if (start && !busy) exp_idx = 0;
         if (bus_if.s_valid && bus_if.s_ready) begin
            sb_q.push_back({BASE + 32'(exp_idx) * 32'd4, bus_if.s_data});
            exp_idx++;
         end
      end
   end

   // Scoreboard consumer: every memory write must match the oldest entry
   always @(negedge clk) begin
      if (bus_if.imem_we === 1'b1) begin
         n_writes++;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: actual addr=0x%0h required no write", bus_if.imem_addr);
         end else begin
            sb_item = sb_q.pop_front();
            chk("imem_addr", bus_if.imem_addr, sb_item[63:32]);
            chk("imem_data", bus_if.imem_data, sb_item[31:0]);
            chk("imem_load_en", 32'(bus_if.imem_load_en), 32'd1);
         end
      end else if (bus_if.imem_load_en !== 1'b0) begin
         chk("imem_load_en_idle", 32'(bus_if.imem_load_en), 32'd0);
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_core_rst"},  32'(core_rst),  32'd1);
      chk({tag, "_core_hold"}, 32'(core_hold), 32'd0);
      chk({tag, "_s_ready"},   32'(bus_if.s_ready), 32'd0);
      chk({tag, "_imem_we"},   32'(bus_if.imem_we), 32'd0);
      chk({tag, "_load_en"},   32'(bus_if.imem_load_en), 32'd0);
      chk({tag, "_addr"},      bus_if.imem_addr, BASE);
      chk({tag, "_data"},      bus_if.imem_data, 32'd0);
      chk({tag, "_done"},      32'(done),  32'd0);
      chk({tag, "_err"},       32'(err),   32'd0);
      chk({tag, "_busy"},      32'(busy),  32'd0);
      chk({tag, "_words"},     32'(words), 32'd0);
   endtask

   task automatic do_start(input logic [15:0] len);
      start   = 1'b1;
      cfg_len = len;
      step();
      start   = 1'b0;
   endtask

   task automatic send(input logic [31:0] d);
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = d;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   // Counts consecutive core_hold cycles, checking core_rst throughout
   task automatic count_hold(input logic exp_rst, output int n);
      n = 0;
      while (core_hold === 1'b1 && n < 20) begin
         chk("hold_core_rst", 32'(core_rst), 32'(exp_rst));
         n++;
         step();
      end
   endtask

   typedef struct {
      logic [15:0] len;
      logic        exp_err;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         n;
      int         w0;
      logic [6:0] gap_pat;

      vecs[0] = '{16'd0,     1'b1, 1'b0};
      vecs[1] = '{16'd1025,  1'b1, 1'b0};
      vecs[2] = '{16'd1024,  1'b0, 1'b1};
      vecs[3] = '{16'hFFFF,  1'b1, 1'b0};
      vecs[4] = '{16'd1,     1'b0, 1'b1};

      bus_if.s_valid = 1'b0;
      bus_if.s_data  = '0;

      // Reset values
      rst = 1'b0;
      step();
      step();
      check_reset_vals("reset");
      rst = 1'b1;
      step();

      // Basic load of 3 words at full rate, settle, run, then halt/drain
      w0 = n_writes;
      do_start(16'd3);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_s_ready", 32'(bus_if.s_ready), 32'd1);
      send(32'h0050_0093);
      send(32'h0030_0113);
      send(32'h0020_81B3);
      bus_if.s_valid = 1'b0;
      chk("t1_words", 32'(words), 32'd3);
      chk("t1_s_ready_after_last", 32'(bus_if.s_ready), 32'd0);
      count_hold(1'b1, n);
      chk("t1_settle_cycles", 32'(n), 32'(PD));
      chk("t1_run_core_rst", 32'(core_rst), 32'd0);
      chk("t1_writes", 32'(n_writes - w0), 32'd3);
      step();
      chk("t1_run_stays", 32'(core_hold), 32'd0);
      halt = 1'b1;
      step();
      count_hold(1'b0, n);
      chk("t5_drain_cycles", 32'(n), 32'(PD));
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_core_rst", 32'(core_rst), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      halt = 1'b0;
      step();
      chk("t5_done_pulse", 32'(done), 32'd0);

      // Gapped stream of 4 words; valid stays high after the last accept
      w0 = n_writes;
      do_start(16'd4);
      gap_pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
      for (int i = 0; i < 7; i++) begin
         bus_if.s_valid = gap_pat[i];
         bus_if.s_data  = 32'hA000_0000 + 32'(i);
         step();
      end
      chk("t2_s_ready_after_last", 32'(bus_if.s_ready), 32'd0);
      chk("t2_words", 32'(words), 32'd4);
      halt = 1'b1;  // already high when RUN is entered
      count_hold(1'b1, n);
      chk("t2_settle_cycles", 32'(n), 32'(PD));
      chk("t2_run_core_rst", 32'(core_rst), 32'd0);
      step();
      chk("t2_run_one_cycle", 32'(core_hold), 32'd1);
      count_hold(1'b0, n);
      chk("t2_drain_cycles", 32'(n), 32'(PD));
      chk("t2_done", 32'(done), 32'd1);
      bus_if.s_valid = 1'b0;
      halt = 1'b0;
      step();
      chk("t2_writes", 32'(n_writes - w0), 32'd4);

      // Timeout after one of two words
      do_start(16'd2);
      send(32'h1111_0001);
      bus_if.s_valid = 1'b0;
      repeat (TO - 1) step();
      chk("t3_busy_before_timeout", 32'(busy), 32'd1);
      chk("t3_err_before_timeout", 32'(err), 32'd0);
      step();
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_idle", 32'(busy), 32'd0);
      chk("t3_core_rst", 32'(core_rst), 32'd1);
      chk("t3_words", 32'(words), 32'd1);
      do_start(16'd1);
      chk("t3_err_cleared", 32'(err), 32'd0);
      chk("t3_busy_again", 32'(busy), 32'd1);
      do_reset();

      // Length legality table
      w0 = n_writes;
      for (int i = 0; i < 5; i++) begin
         do_start(vecs[i].len);
         chk("t4_err", 32'(err), 32'(vecs[i].exp_err));
         chk("t4_busy", 32'(busy), 32'(vecs[i].exp_busy));
         chk("t4_s_ready", 32'(bus_if.s_ready), 32'(vecs[i].exp_busy));
         if (busy) do_reset();
      end
      step();
      chk("t4_no_writes", 32'(n_writes - w0), 32'd0);

      // A start while busy is ignored, even an illegal one
      do_start(16'd3);
      do_start(16'd0);
      chk("busy_start_err", 32'(err), 32'd0);
      chk("busy_start_busy", 32'(busy), 32'd1);
      do_reset();

      // Reset after the 2nd of 5 words, then a fresh load from BASE
      do_start(16'd5);
      send(32'h2222_0000);
      send(32'h2222_0001);
      bus_if.s_valid = 1'b0;
      rst = 1'b0;
      step();
      check_reset_vals("t6_midload");
      rst = 1'b1;
      step();
      w0 = n_writes;
      do_start(16'd2);
      send(32'h3333_0000);
      send(32'h3333_0001);
      bus_if.s_valid = 1'b0;
      step();
      chk("t6_writes", 32'(n_writes - w0), 32'd2);
      chk("t6_words", 32'(words), 32'd2);
      chk("t6_queue_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
